// File: rtl/csp_pkg.sv
// csp_pkg: shared types and the 1-of-4 digit encoder for the CSP channel.
package csp_pkg;
  typedef enum logic [1:0] {CH_IDLE, CH_SND_WAIT, CH_RCV_WAIT, CH_DONE} ch_state_t;
  function automatic logic [3:0] p1of4_encode(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction
endpackage

// File: rtl/csp_p1of4_enc.sv
// csp_p1of4_enc: combinational re-encoding of a word into 1-of-4 nibbles, one per 2-bit digit.
module csp_p1of4_enc
  import csp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   data,
  output logic [2*WIDTH-1:0] code
);
  for (genvar i = 0; i < WIDTH / 2; i++) begin : g_dig
    assign code[4*i+:4] = p1of4_encode(data[2*i+:2]);
  end
endmodule

// File: rtl/csp_channel.sv
// csp_channel: zero-slack rendezvous channel with transfer count and one-sided stall detection.
module csp_channel
  import csp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 snd_req,
  input  logic [WIDTH-1:0]     snd_data,
  output logic                 snd_done,
  input  logic                 rcv_req,
  output logic [WIDTH-1:0]     rcv_data,
  output logic                 rcv_done,
  output logic [2*WIDTH-1:0]   rcv_p1of4,
  output logic [CNT_W-1:0]     xfer_cnt,
  output logic                 snd_stall,
  output logic                 rcv_stall
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

  logic              fire, done_q, done_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              snd_stall_q, snd_stall_d, rcv_stall_q, rcv_stall_d;
  logic              timed_out;
  ch_state_t         state;

  always_comb begin
    fire = snd_req & rcv_req & ~done_q;
    state = (snd_req ^ rcv_req) ? (snd_req ? CH_SND_WAIT : CH_RCV_WAIT)
                                : (done_q ? CH_DONE : CH_IDLE);
    timed_out = wait_q == TMO;
    done_d = fire;
    data_d = fire ? snd_data : data_q;
    xfer_cnt_d = xfer_cnt_q + CNT_W'(fire);
    wait_d = (fire | ~(snd_req | rcv_req)) ? '0
           : ((state inside {CH_SND_WAIT, CH_RCV_WAIT}) && !timed_out) ? wait_q + WAIT_W'(1)
           : wait_q;
    // setting one flag clears the other so at most one side is ever reported stalled
    snd_stall_d = fire ? 1'b0
                : (timed_out && state == CH_SND_WAIT) ? 1'b1
                : (timed_out && state == CH_RCV_WAIT) ? 1'b0
                : snd_stall_q;
    rcv_stall_d = fire ? 1'b0
                : (timed_out && state == CH_RCV_WAIT) ? 1'b1
                : (timed_out && state == CH_SND_WAIT) ? 1'b0
                : rcv_stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      data_q      <= '0;
      xfer_cnt_q  <= '0;
      wait_q      <= '0;
      snd_stall_q <= 1'b0;
      rcv_stall_q <= 1'b0;
    end else begin
      done_q      <= done_d;
      data_q      <= data_d;
      xfer_cnt_q  <= xfer_cnt_d;
      wait_q      <= wait_d;
      snd_stall_q <= snd_stall_d;
      rcv_stall_q <= rcv_stall_d;
    end
  end

  csp_p1of4_enc #(.WIDTH(WIDTH)) u_enc (.data(data_q), .code(rcv_p1of4));

  assign snd_done  = done_q;
  assign rcv_done  = done_q;
  assign rcv_data  = data_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign snd_stall = snd_stall_q;
  assign rcv_stall = rcv_stall_q;
endmodule

// File: tb/tb_csp_channel.sv
// tb_csp_channel: directed rendezvous, stall, wrap and reset scenarios with a queue-based scoreboard.
module tb_csp_channel;
  logic        clk = 0, rst_n, snd_req, rcv_req, snd_done, rcv_done, snd_stall, rcv_stall;
  logic [7:0]  snd_data, rcv_data;
  logic [15:0] rcv_p1of4;
  logic [3:0]  xfer_cnt;
  logic [3:0]  exp_cnt = 0;
  logic [27:0] exp_q[$];
  int          n_cmp = 0, n_bad = 0, n_done = 0;
  logic        prev_done = 0;

  csp_channel #(.WIDTH(8), .TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .snd_req(snd_req), .snd_data(snd_data), .snd_done(snd_done),
    .rcv_req(rcv_req), .rcv_data(rcv_data), .rcv_done(rcv_done), .rcv_p1of4(rcv_p1of4),
    .xfer_cnt(xfer_cnt), .snd_stall(snd_stall), .rcv_stall(rcv_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [15:0] p);
    exp_cnt = exp_cnt + 4'd1;
    exp_q.push_back({d, p, exp_cnt});
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rcv_done) break;
    end
    if (i == 20) chk({name, "_timeout"}, 0, 1);
  endtask

  // monitor: every done pulse must match the oldest expected transfer
  always @(negedge clk) begin
    if (rcv_done) begin
      n_done++;
      if (prev_done) chk("back_to_back_done", 1, 0);
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("xfer", {3'b0, snd_done, rcv_data, rcv_p1of4, xfer_cnt}, {4'b0001, exp_q.pop_front()});
    end
    prev_done = rcv_done;
  end

  logic [7:0]  dat [9] = '{8'h00, 8'hFF, 8'h1B, 8'h55, 8'hAA, 8'h12, 8'h80, 8'h3C, 8'hC3};
  logic [15:0] cod [9] = '{16'h1111, 16'h8888, 16'h1248, 16'h2222, 16'h4444,
                           16'h1214, 16'h4111, 16'h1881, 16'h8118};

  initial begin
    rst_n = 0; snd_req = 0; rcv_req = 0; snd_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", rcv_data, 0);
    chk("rst_p1of4", rcv_p1of4, 16'h1111);
    chk("rst_done", {snd_done, rcv_done}, 0);
    chk("rst_cnt_stall", {xfer_cnt, snd_stall, rcv_stall}, 0);
    rst_n = 1;
    // sender first, receiver three cycles later
    @(posedge clk); #1 snd_req = 1; snd_data = 8'h01; push(8'h01, 16'h1112);
    repeat (3) @(posedge clk);
    #1 chk("no_early_done", rcv_done, 0);
    rcv_req = 1;
    wait_done("t2");
    @(posedge clk); #1 snd_req = 0; rcv_req = 0;
    // both held for 10 cycles: five transfers
    @(posedge clk); #1 snd_data = 8'hE4; snd_req = 1; rcv_req = 1;
    for (int i = 0; i < 5; i++) push(8'hE4, 16'h8421);
    repeat (10) @(posedge clk);
    #1 snd_req = 0; rcv_req = 0;
    @(negedge clk);
    chk("t3_done_count", n_done, 6);
    // receive/receive deadlock
    @(posedge clk); #1 rcv_req = 1;
    repeat (15) @(posedge clk);
    #1 chk("t4_no_stall_yet", {snd_stall, rcv_stall}, 0);
    repeat (5) @(posedge clk);
    #1 chk("t4_rcv_stall", {snd_stall, rcv_stall}, 2'b01);
    chk("t4_cnt", xfer_cnt, 6);
    chk("t4_no_done", n_done, 6);
    // recovery
    snd_data = 8'h00; snd_req = 1; push(8'h00, 16'h1111);
    @(posedge clk); #1 chk("t5_stall_clear", rcv_stall, 0);
    snd_req = 0; rcv_req = 0;
    // send/send deadlock and recovery
    @(posedge clk); #1 snd_data = 8'hA5; snd_req = 1;
    repeat (20) @(posedge clk);
    #1 chk("snd_stall", {snd_stall, rcv_stall}, 2'b10);
    rcv_req = 1; push(8'hA5, 16'h4422);
    @(posedge clk); #1 chk("snd_stall_clear", snd_stall, 0);
    snd_req = 0; rcv_req = 0;
    // nine more transfers: 17 total wraps the 4-bit counter to 1
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1 snd_data = dat[i]; snd_req = 1; rcv_req = 1; push(dat[i], cod[i]);
      @(posedge clk); #1 snd_req = 0; rcv_req = 0;
    end
    @(posedge clk); #1 chk("wrap_cnt", xfer_cnt, 1);
    chk("total_done", n_done, 17);
    // reset mid-transfer
    @(posedge clk); #1 snd_data = 8'h77; snd_req = 1; rcv_req = 1;
    #2 rst_n = 0;
    #1 chk("mid_rst_data", rcv_data, 0);
    chk("mid_rst_p1of4", rcv_p1of4, 16'h1111);
    chk("mid_rst_rest", {snd_done, rcv_done, xfer_cnt, snd_stall, rcv_stall}, 0);
    @(posedge clk); #1 chk("held_rst_data", rcv_data, 0);
    snd_req = 0; rcv_req = 0; rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_cnt", xfer_cnt, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
